// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad serial configuration sequencer.
package gpio_cfg_pkg;

  localparam int unsigned SRST_CYCLES = 2;
  localparam int unsigned DIV_W       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSrst,
    StShiftLo,
    StShiftHi,
    StLoad,
    StDone
  } cfg_state_e;

  function automatic int unsigned total_bits(input int unsigned num_pads,
                                             input int unsigned pad_bits);
    return num_pads * pad_bits;
  endfunction

endpackage

// File: rtl/gpio_cfg_divider.sv
// Half-period tick counter: reload on state entry, tick on the last cycle of the phase.
module gpio_cfg_divider
  import gpio_cfg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             reload_i,
  input  logic [DIV_W-1:0] reload_val_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (reload_i) begin
      cnt_q <= reload_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A phase loaded with N lasts exactly N cycles; the tick marks its final cycle.
  assign tick_o = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Serial configuration chain master: snapshots the pad image, resets the chain,
// shifts the image MSB first and strobes load.
module gpio_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int unsigned NUM_PADS      = 14,
  parameter int unsigned PAD_CTRL_BITS = 16,
  parameter int unsigned CLK_DIV       = 4,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic                              mclk,
  input  logic                              resetn,
  input  logic [NUM_PADS*PAD_CTRL_BITS-1:0] cfg_data,
  input  logic                              cfg_start,
  output logic                              cfg_busy,
  output logic                              cfg_done,
  output logic                              serial_shift_rstn,
  output logic                              serial_clock,
  output logic                              serial_data,
  output logic                              serial_load
);

  localparam int unsigned TOTAL = total_bits(NUM_PADS, PAD_CTRL_BITS);
  localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [DIV_W-1:0] HALF = DIV_W'(CLK_DIV);

  cfg_state_e       state_q;
  logic [TOTAL-1:0] shadow_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             auto_q;

  logic             start_req;
  logic             tick;
  logic             div_reload;
  logic [DIV_W-1:0] div_val;

  // auto_q is only set out of reset, so it behaves as a one-shot start request.
  assign start_req = cfg_start | auto_q;

  // Divider reload accompanies every state transition; value is the next phase length.
  always_comb begin
    div_reload = 1'b0;
    div_val    = HALF;
    case (state_q)
      StIdle: begin
        div_reload = start_req;
        div_val    = DIV_W'(SRST_CYCLES);
      end
      StSrst, StShiftLo, StShiftHi: div_reload = tick;
      StLoad: begin
        div_reload = tick;
        div_val    = '0;
      end
      StDone: begin
        div_reload = 1'b1;
        div_val    = '0;
      end
      default: ;
    endcase
  end

  gpio_cfg_divider u_divider (
    .clk_i        (mclk),
    .rst_ni       (resetn),
    .reload_i     (div_reload),
    .reload_val_i (div_val),
    .tick_o       (tick)
  );

  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      state_q           <= StIdle;
      shadow_q          <= '0;
      bit_cnt_q         <= '0;
      auto_q            <= AUTO_START;
      cfg_busy          <= 1'b0;
      cfg_done          <= 1'b0;
      serial_shift_rstn <= 1'b1;
      serial_clock      <= 1'b0;
      serial_data       <= 1'b0;
      serial_load       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_req) begin
            shadow_q          <= cfg_data;
            bit_cnt_q         <= CNT_W'(TOTAL - 1);
            auto_q            <= 1'b0;
            cfg_busy          <= 1'b1;
            serial_shift_rstn <= 1'b0;
            state_q           <= StSrst;
          end
        end
        StSrst: begin
          if (tick) begin
            serial_shift_rstn <= 1'b1;
            serial_clock      <= 1'b0;
            serial_data       <= shadow_q[bit_cnt_q];
            state_q           <= StShiftLo;
          end
        end
        StShiftLo: begin
          if (tick) begin
            serial_clock <= 1'b1;
            state_q      <= StShiftHi;
          end
        end
        StShiftHi: begin
          if (tick) begin
            serial_clock <= 1'b0;
            if (bit_cnt_q == '0) begin
              serial_data <= 1'b0;
              serial_load <= 1'b1;
              state_q     <= StLoad;
            end else begin
              bit_cnt_q   <= bit_cnt_q - 1'b1;
              serial_data <= shadow_q[bit_cnt_q - 1'b1];
              state_q     <= StShiftLo;
            end
          end
        end
        StLoad: begin
          if (tick) begin
            serial_load <= 1'b0;
            cfg_busy    <= 1'b0;
            cfg_done    <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          cfg_done <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
